// File: rtl/ksa_pkg.sv
// Shared types and the generate/propagate prefix operator for the Kogge-Stone adder.
package ksa_pkg;

  localparam int KSA_WIDTH  = 32;
  localparam int KSA_LEVELS = 5;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Associative prefix operator: hi is the more significant group.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage

// File: rtl/ksa_gp_cell.sv
// Black cell of the prefix tree: merges a high group with the adjacent lower group.
module ksa_gp_cell
  import ksa_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  gp_t w_res;

  assign w_res = gp_combine(gp_t'{g: g_hi, p: p_hi}, gp_t'{g: g_lo, p: p_lo});
  assign g_out = w_res.g;
  assign p_out = w_res.p;

endmodule

// File: rtl/ksa_top.sv
// Kogge-Stone adder/subtractor: cin=0 adds, cin=1 subtracts (a + ~b + 1).
// Optional output register stage with asynchronous clear when PIPE=1.
module ksa_top
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH,
  parameter int PIPE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("ksa_top: WIDTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g_seed;
  logic [WIDTH-1:0] w_g_fin;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_bb = b ^ {WIDTH{cin}};
  assign w_g  = a & w_bb;
  assign w_p  = a ^ w_bb;

  // cin is folded into bit 0 so every group G already includes the carry-in.
  assign w_g_seed = {w_g[WIDTH-1:1], w_g[0] | (w_p[0] & cin)};

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] w_g_in;
    logic [WIDTH-1:0] w_p_in;
    logic [WIDTH-1:0] w_g_out;
    logic [WIDTH-1:0] w_p_out;

    if (k == 0) begin : g_first
      assign w_g_in = w_g_seed;
      assign w_p_in = w_p;
    end else begin : g_next
      assign w_g_in = g_lvl[k-1].w_g_out;
      assign w_p_in = g_lvl[k-1].w_p_out;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_cell
        ksa_gp_cell u_cell (
          .g_hi  (w_g_in[i]),
          .p_hi  (w_p_in[i]),
          .g_lo  (w_g_in[i-(1<<k)]),
          .p_lo  (w_p_in[i-(1<<k)]),
          .g_out (w_g_out[i]),
          .p_out (w_p_out[i])
        );
      end else begin : g_pass
        assign w_g_out[i] = w_g_in[i];
        assign w_p_out[i] = w_p_in[i];
      end
    end
  end

  assign w_g_fin = g_lvl[LEVELS-1].w_g_out;

  // The final group propagate has no consumer; only group generate feeds carries.
  logic w_unused_pfin;
  assign w_unused_pfin = ^g_lvl[LEVELS-1].w_p_out;

  assign w_carry = {w_g_fin[WIDTH-2:0], cin};
  assign w_sum   = w_p ^ w_carry;
  assign w_cout  = w_g_fin[WIDTH-1];

  if (PIPE != 0) begin : g_pipe
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sum  <= '0;
        r_cout <= 1'b0;
      end else begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
  end else begin : g_comb
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
    assign sum  = w_sum;
    assign cout = w_cout;
  end

endmodule

// File: tb/tb_ksa_top.sv
// Bench for ksa_top: directed table, randomized add/sub against an arithmetic
// model, and register-stage reset/latency sequences on a PIPE=1 instance.
module tb_ksa_top;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] a, b, sum;
  logic         cin, cout;
  logic [W-1:0] pa, pb, psum;
  logic         pcin, pcout;

  ksa_top #(.WIDTH(W), .PIPE(0)) u_comb (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  ksa_top #(.WIDTH(W), .PIPE(1)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .a    (pa),
    .b    (pb),
    .cin  (pcin),
    .sum  (psum),
    .cout (pcout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: plain arithmetic on the operation the mode selects
  function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] r;
    if (c) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act_s, input logic act_c,
                       input logic [W-1:0] exp_s, input logic exp_c);
    n_vec++;
    if (act_s !== exp_s || act_c !== exp_c) begin
      n_bad++;
      $display("FAIL %s: got sum=%h cout=%b, want sum=%h cout=%b",
               name, act_s, act_c, exp_s, exp_c);
    end
  endtask

  task automatic drive_comb(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c;
    #5;
  endtask

  vec_t       tbl[$];
  logic [W:0] r;
  int         bad_before;

  initial begin
    a = '0; b = '0; cin = 1'b0;
    pa = '0; pb = '0; pcin = 1'b0;

    tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0});
    tbl.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1});
    tbl.push_back('{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0});

    // PIPE=1 reset state while rst is held
    #3;
    check("pipe_reset_state", psum, pcout, 32'h0, 1'b0);

    foreach (tbl[i]) begin
      drive_comb(tbl[i].a, tbl[i].b, tbl[i].cin);
      check($sformatf("table[%0d]", i), sum, cout, tbl[i].exp_sum, tbl[i].exp_cout);
    end

    for (int m = 0; m < 2; m++) begin
      bad_before = n_bad;
      for (int i = 0; i < 10000; i++) begin
        logic [W-1:0] x, y;
        x = $urandom();
        y = $urandom();
        case ($urandom_range(0, 15))
          0: y = x;
          1: x = '1;
          2: y = '1;
          default: ;
        endcase
        drive_comb(x, y, m[0]);
        r = ref_model(x, y, m[0]);
        check($sformatf("random_%s a=%h b=%h", m[0] ? "sub" : "add", x, y),
              sum, cout, r[W-1:0], r[W]);
        if (n_bad != bad_before) break;
      end
    end

    // PIPE=1: release reset, check one-cycle latency
    @(negedge clk);
    rst = 1'b0;
    pa = 32'h1; pb = 32'h2; pcin = 1'b0;
    #1;
    check("pipe_hold_before_edge", psum, pcout, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("pipe_first_capture", psum, pcout, 32'h3, 1'b0);

    @(negedge clk);
    pa = 32'h5; pb = 32'h7; pcin = 1'b1;
    @(posedge clk); #1;
    check("pipe_sub_borrow", psum, pcout, 32'hFFFF_FFFE, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] x, y;
      logic c;
      @(negedge clk);
      x = $urandom(); y = $urandom(); c = 1'($urandom_range(0, 1));
      pa = x; pb = y; pcin = c;
      r = ref_model(x, y, c);
      #1;
      if (i > 0) ;
      @(posedge clk); #1;
      check($sformatf("pipe_random[%0d]", i), psum, pcout, r[W-1:0], r[W]);
    end

    // asynchronous reset mid-stream, away from any clock edge
    @(negedge clk);
    pa = 32'hFFFF_FFFF; pb = 32'h1; pcin = 1'b0;
    @(posedge clk); #1;
    check("pipe_pre_reset", psum, pcout, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("pipe_async_reset", psum, pcout, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("pipe_reset_held", psum, pcout, 32'h0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    pa = 32'h3; pb = 32'h4; pcin = 1'b0;
    #1;
    check("pipe_post_reset_no_edge", psum, pcout, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("pipe_post_reset_capture", psum, pcout, 32'h7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
